// File: rtl/axis_stream_arbiter.sv
// Packet-level round-robin arbiter merging up to four AXI-Stream sources.
// Optional stall watchdog enabled with `define ARB_WATCHDOG_EN.
module axis_stream_arbiter #(
    parameter int DATA_SIZE      = 32,
    parameter int NUM_SRC        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          m00_axis_aclk,
    input  logic                          m00_axis_areset,
    input  logic                          m00_axis_enable,
    input  logic [NUM_SRC-1:0]            src_enable_mask,
    output logic [NUM_SRC-1:0]            src_enable,
    input  logic [NUM_SRC*DATA_SIZE-1:0]  s_axis_tdata,
    input  logic [NUM_SRC*DATA_SIZE/8-1:0] s_axis_tstrb,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    output logic [DATA_SIZE-1:0]          m00_axis_tdata,
    output logic [DATA_SIZE/8-1:0]        m00_axis_tstrb,
    output logic                          m00_axis_tvalid,
    output logic                          m00_axis_tlast,
    input  logic                          m00_axis_tready,
    output logic [1:0]                    grant_id,
    output logic                          busy,
    output logic                          timeout_flag
);

    localparam int SW = DATA_SIZE / 8;

    if (NUM_SRC < 2 || NUM_SRC > 4) begin : g_bad_num_src
        $error("NUM_SRC must be in 2..4");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t       state_q;
    logic [1:0]   grant_q;
    logic [1:0]   last_q;
    logic         busy_q;
    logic [NUM_SRC-1:0] eligible;
    logic [3:0]   elig4;
    logic [1:0]   cand;
    logic [1:0]   pick_d;
    logic         pick_found_d;
    logic         xfer;
    logic         xfer_last;

    assign src_enable = {NUM_SRC{m00_axis_enable}} & src_enable_mask;
    assign eligible   = src_enable & s_axis_tvalid;
    assign elig4      = 4'(eligible);
    assign grant_id   = grant_q;
    assign busy       = busy_q;
    assign xfer       = m00_axis_tvalid & m00_axis_tready;
    assign xfer_last  = xfer & m00_axis_tlast;

    // Round-robin search: first eligible index after last_q, smallest distance wins.
    always_comb begin
        pick_d       = 2'd0;
        pick_found_d = 1'b0;
        cand         = 2'd0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = 2'((int'(last_q) + k) % NUM_SRC);
            if (elig4[cand]) begin
                pick_d       = cand;
                pick_found_d = 1'b1;
            end
        end
    end

    // Zero-latency output mux and ready steering for the granted source.
    always_comb begin
        m00_axis_tdata  = '0;
        m00_axis_tstrb  = '0;
        m00_axis_tvalid = 1'b0;
        m00_axis_tlast  = 1'b0;
        s_axis_tready   = '0;
        if (state_q == GRANT) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant_q == 2'(i)) begin
                    m00_axis_tdata   = s_axis_tdata[i*DATA_SIZE +: DATA_SIZE];
                    m00_axis_tstrb   = s_axis_tstrb[i*SW +: SW];
                    m00_axis_tvalid  = s_axis_tvalid[i];
                    m00_axis_tlast   = s_axis_tlast[i];
                    s_axis_tready[i] = m00_axis_tready;
                end
            end
        end
    end

`ifdef ARB_WATCHDOG_EN
    logic [7:0] wdog_q;
    logic [7:0] wdog_d;
    logic       tflag_q;
    logic       wdog_hit;

    assign wdog_hit     = (state_q == GRANT) && !m00_axis_tvalid &&
                          (wdog_q == 8'(TIMEOUT_CYCLES - 1));
    assign timeout_flag = tflag_q;

    // Stall counter: cleared outside GRANT and on each transferred beat.
    always_comb begin
        wdog_d = wdog_q;
        if (state_q != GRANT || xfer) begin
            wdog_d = 8'd0;
        end else if (!m00_axis_tvalid) begin
            wdog_d = wdog_q + 8'd1;
        end
    end

    // Watchdog counter register and sticky timeout event flag.
    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            wdog_q  <= 8'd0;
            tflag_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            if (wdog_hit) begin
                tflag_q <= 1'b1;
            end
        end
    end
`else
    logic wdog_hit;

    assign wdog_hit     = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // Arbitration FSM: grant held from first beat until the tlast beat.
    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            state_q <= IDLE;
            grant_q <= 2'd0;
            last_q  <= 2'(NUM_SRC - 1);
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_found_d) begin
                        grant_q <= pick_d;
                        last_q  <= pick_d;
                        state_q <= GRANT;
                        busy_q  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (xfer_last || wdog_hit) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_stream_arbiter.sv
// Directed self-checking bench for axis_stream_arbiter.
// Watchdog scenario adapts to whether ARB_WATCHDOG_EN is defined.
module tb_axis_stream_arbiter;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  mask;
    logic [3:0]  src_en;
    logic [127:0] s_tdata;
    logic [15:0] s_tstrb;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tlast;
    logic [3:0]  s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic [1:0]  gid;
    logic        busy;
    logic        tflag;

    axis_stream_arbiter #(
        .DATA_SIZE(32),
        .NUM_SRC(4),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .m00_axis_aclk(clk),
        .m00_axis_areset(rst),
        .m00_axis_enable(en),
        .src_enable_mask(mask),
        .src_enable(src_en),
        .s_axis_tdata(s_tdata),
        .s_axis_tstrb(s_tstrb),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m00_axis_tdata(m_tdata),
        .m00_axis_tstrb(m_tstrb),
        .m00_axis_tvalid(m_tvalid),
        .m00_axis_tlast(m_tlast),
        .m00_axis_tready(m_tready),
        .grant_id(gid),
        .busy(busy),
        .timeout_flag(tflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    int          len   [4];
    int          left  [4];
    int          beat  [4];
    logic [31:0] base  [4];
    bit          stall [4];

    int          lg_gid [$];
    logic [31:0] lg_dat [$];
    bit          lg_lst [$];
    int          lg_cyc [$];
    logic [3:0]  tr_or;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            s_tvalid[i] = (left[i] > 0) && !stall[i];
            s_tlast[i]  = (beat[i] == len[i] - 1);
            s_tdata[i*32 +: 32] = base[i] + 32'(beat[i]);
            s_tstrb[i*4 +: 4]   = 4'(i + 1);
        end
    endtask

    task automatic clr_log();
        lg_gid.delete();
        lg_dat.delete();
        lg_lst.delete();
        lg_cyc.delete();
        tr_or = 4'd0;
    endtask

    task automatic clr_src();
        for (int i = 0; i < 4; i++) begin
            len[i]   = 1;
            left[i]  = 0;
            beat[i]  = 0;
            base[i]  = 32'd0;
            stall[i] = 1'b0;
        end
    endtask

    task automatic cyc();
        logic [3:0] hs;
        hs = s_tready & s_tvalid;
        tr_or = tr_or | s_tready;
        if (m_tvalid && m_tready) begin
            lg_gid.push_back(int'(gid));
            lg_dat.push_back(m_tdata);
            lg_lst.push_back(m_tlast);
            lg_cyc.push_back(cyc_n);
        end
        @(posedge clk);
        #1;
        cyc_n++;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                if (beat[i] == len[i] - 1) begin
                    beat[i] = 0;
                    left[i]--;
                end else begin
                    beat[i]++;
                end
            end
        end
        drive();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        run(2);
        rst = 1'b0;
        #1;
    endtask

    int exp_g [4] = '{0, 1, 2, 3};
    int g;

    initial begin
        rst = 1'b1;
        en = 1'b0;
        mask = 4'b1111;
        m_tready = 1'b1;
        s_tdata = '0;
        s_tstrb = '0;
        s_tvalid = '0;
        s_tlast = '0;
        clr_src();
        clr_log();
        drive();
        #2;
        run(2);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gid", 32'(gid), 32'd0);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_tstrb", 32'(m_tstrb), 32'd0);
        check("rst_tready", 32'(s_tready), 32'd0);
        check("rst_tflag", 32'(tflag), 32'd0);
        rst = 1'b0;
        #1;

        // Round robin over four 2-beat packets, source 0 has two packets.
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            len[i]  = 2;
            left[i] = (i == 0) ? 2 : 1;
            base[i] = 32'h10 * 32'(i);
        end
        settle();
        check("rr_src_en", 32'(src_en), 32'hF);
        clr_log();
        run(16);
        check("rr_count", 32'(lg_gid.size()), 32'd10);
        for (int i = 0; i < 10 && i < lg_gid.size(); i++) begin
            g = (i < 8) ? exp_g[i/2] : 0;
            check($sformatf("rr_gid%0d", i), 32'(lg_gid[i]), 32'(g));
            check($sformatf("rr_dat%0d", i), lg_dat[i],
                  32'h10 * 32'(g) + 32'(i % 2));
            check($sformatf("rr_lst%0d", i), 32'(lg_lst[i]), 32'(i % 2));
            check($sformatf("rr_cyc%0d", i), 32'(lg_cyc[i] - lg_cyc[0]),
                  32'((i / 2) * 3 + (i % 2)));
        end
        check("rr_idle", 32'(busy), 32'd0);

        // Only source 2 valid with a 3-beat packet.
        clr_src();
        len[2] = 3;
        left[2] = 1;
        base[2] = 32'hA0;
        settle();
        clr_log();
        run(8);
        check("s2_count", 32'(lg_gid.size()), 32'd3);
        for (int i = 0; i < 3 && i < lg_gid.size(); i++) begin
            check($sformatf("s2_gid%0d", i), 32'(lg_gid[i]), 32'd2);
            check($sformatf("s2_dat%0d", i), lg_dat[i], 32'hA0 + 32'(i));
            check($sformatf("s2_lst%0d", i), 32'(lg_lst[i]), 32'(i == 2));
        end
        check("s2_tready", 32'(tr_or), 32'b0100);

        // Downstream stall for 5 cycles mid-packet.
        clr_src();
        len[1] = 3;
        left[1] = 1;
        base[1] = 32'h30;
        settle();
        clr_log();
        run(2);
        m_tready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check($sformatf("st_dat%0d", i), m_tdata, 32'h31);
            check($sformatf("st_vld%0d", i), 32'(m_tvalid), 32'd1);
            check($sformatf("st_rdy%0d", i), 32'(s_tready), 32'd0);
        end
        check("st_strb", 32'(m_tstrb), 32'h2);
        m_tready = 1'b1;
        #1;
        run(4);
        check("st_count", 32'(lg_gid.size()), 32'd3);
        for (int i = 0; i < 3 && i < lg_gid.size(); i++) begin
            check($sformatf("st_out%0d", i), lg_dat[i], 32'h30 + 32'(i));
            check($sformatf("st_lst%0d", i), 32'(lg_lst[i]), 32'(i == 2));
        end

        // Mask narrowed to source 0 while source 1 is granted.
        clr_src();
        len[1] = 3;
        left[1] = 1;
        base[1] = 32'h40;
        settle();
        clr_log();
        run(1);
        check("mk_gid", 32'(gid), 32'd1);
        mask = 4'b0001;
        len[0] = 2;
        left[0] = 2;
        base[0] = 32'h50;
        len[2] = 2;
        left[2] = 1;
        base[2] = 32'h60;
        len[3] = 2;
        left[3] = 1;
        base[3] = 32'h70;
        settle();
        check("mk_src_en", 32'(src_en), 32'b0001);
        run(11);
        check("mk_count", 32'(lg_gid.size()), 32'd7);
        for (int i = 0; i < 7 && i < lg_gid.size(); i++) begin
            check($sformatf("mk_gid%0d", i), 32'(lg_gid[i]),
                  (i < 3) ? 32'd1 : 32'd0);
            check($sformatf("mk_dat%0d", i), lg_dat[i],
                  (i < 3) ? 32'h40 + 32'(i) : 32'h50 + 32'((i - 3) % 2));
        end
        check("mk_busy", 32'(busy), 32'd0);
        check("mk_tvalid", 32'(m_tvalid), 32'd0);
        mask = 4'b1111;
        left[2] = 0;
        left[3] = 0;
        settle();

        // Reset pulse in the middle of a source 3 packet.
        clr_src();
        len[3] = 4;
        left[3] = 1;
        base[3] = 32'h80;
        settle();
        clr_log();
        run(2);
        check("rp_pre_gid", 32'(gid), 32'd3);
        len[1] = 2;
        left[1] = 1;
        base[1] = 32'h90;
        settle();
        rst = 1'b1;
        #1;
        check("rp_tvalid", 32'(m_tvalid), 32'd0);
        check("rp_gid", 32'(gid), 32'd0);
        check("rp_busy", 32'(busy), 32'd0);
        check("rp_tready", 32'(s_tready), 32'd0);
        run(1);
        rst = 1'b0;
        #1;
        clr_log();
        run(1);
        check("rp_next_gid", 32'(gid), 32'd1);
        check("rp_next_busy", 32'(busy), 32'd1);
        run(10);
        check("rp_count", 32'(lg_gid.size()), 32'd5);
        if (lg_gid.size() >= 3) begin
            check("rp_first", 32'(lg_gid[0]), 32'd1);
            check("rp_third", 32'(lg_gid[2]), 32'd3);
            check("rp_third_d", lg_dat[2], 32'h81);
        end

        // Source 0 stalls after its first beat.
        clr_src();
        do_reset();
        len[0] = 2;
        left[0] = 1;
        base[0] = 32'hC0;
        len[1] = 1;
        left[1] = 1;
        base[1] = 32'hD0;
        settle();
        clr_log();
        run(2);
        stall[0] = 1'b1;
        settle();
        check("wd_beat0", 32'(lg_gid.size()), 32'd1);
`ifdef ARB_WATCHDOG_EN
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("wd_hold%0d", i), 32'(busy), 32'd1);
            check($sformatf("wd_flag%0d", i), 32'(tflag), 32'd0);
        end
        cyc();
        check("wd_idle", 32'(busy), 32'd0);
        check("wd_flag", 32'(tflag), 32'd1);
        cyc();
        check("wd_next_gid", 32'(gid), 32'd1);
        check("wd_next_busy", 32'(busy), 32'd1);
        cyc();
        check("wd_single_d", m_tdata, 32'hD0);
        check("wd_single_l", 32'(m_tlast), 32'd1);
        stall[0] = 1'b0;
        settle();
        run(6);
        check("wd_sticky", 32'(tflag), 32'd1);
        check("wd_done", 32'(busy), 32'd0);
`else
        run(10);
        check("wd_hold_busy", 32'(busy), 32'd1);
        check("wd_hold_gid", 32'(gid), 32'd0);
        check("wd_hold_vld", 32'(m_tvalid), 32'd0);
        check("wd_flag", 32'(tflag), 32'd0);
        stall[0] = 1'b0;
        settle();
        check("wd_resume_d", m_tdata, 32'hC1);
        run(6);
        check("wd_count", 32'(lg_gid.size()), 32'd3);
        if (lg_gid.size() >= 3) begin
            check("wd_last0", 32'(lg_lst[1]), 32'd1);
            check("wd_single", lg_dat[2], 32'hD0);
            check("wd_single_g", 32'(lg_gid[2]), 32'd1);
        end
        check("wd_done", 32'(busy), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
